// File: rtl/key_expansion_seq_if.sv
// Bus interface for key_expansion_seq: start request, key input and the
// round-key output stream. The design side uses the slave modport.
//
// Handshake: a round key transfers on a rising edge where rk_valid and
// rk_ready are both 1. Once rk_valid rises it stays high, and rk_data and
// rk_idx stay unchanged, until that transfer happens. rk_ready may toggle
// freely and may be high while rk_valid is low.
interface key_expansion_seq_if #(
    parameter int MAX_KEY_BITS = 256
);
    logic                    start;
    logic [MAX_KEY_BITS-1:0] key;
    logic [1:0]              key_len;
    logic                    rk_ready;
    logic                    rk_valid;
    logic [127:0]            rk_data;
    logic [3:0]              rk_idx;
    logic                    busy;
    logic                    done;
    logic                    err;

    modport master (
        output start, key, key_len, rk_ready,
        input  rk_valid, rk_data, rk_idx, busy, done, err
    );

    modport slave (
        input  start, key, key_len, rk_ready,
        output rk_valid, rk_data, rk_idx, busy, done, err
    );
endinterface

// File: rtl/key_expansion_seq.sv
// key_expansion_seq: sequential AES key expansion (AES-128/192/256).
// Produces one expanded word per cycle and emits 128-bit round keys through a
// valid/ready output register. Optional macro KEYEXP_ZEROIZE_EN clears the
// key material when an expansion completes and masks rk_data while it is not
// valid.
module key_expansion_seq #(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    key_expansion_seq_if.slave   bus,
    output logic                 dbg_state   // 1 while the FSM is in EXPAND
);
    localparam int NW = MAX_KEY_BITS / 32;
    localparam logic [9:0] MAX_BITS_W = 10'(MAX_KEY_BITS);

    typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Four independent byte substitutions.
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    state_e                  state_q, state_d;
    logic [MAX_KEY_BITS-1:0] key_q, key_d;
    logic [1:0]              len_q, len_d;
    logic [31:0]             win_q [NW];   // win_q[0] = w[i-1], win_q[k] = w[i-1-k]
    logic [31:0]             win_d [NW];
    logic [31:0]             asm_q [3];    // words 0..2 of the round key being built
    logic [31:0]             asm_d [3];
    logic [5:0]              wcnt_q, wcnt_d;   // index i of the next word
    logic [2:0]              mod_q, mod_d;     // i mod Nk
    logic [7:0]              rcon_q, rcon_d;
    logic                    rk_valid_q, rk_valid_d;
    logic [127:0]            rk_data_q, rk_data_d;
    logic [3:0]              rk_idx_q, rk_idx_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic [3:0]  nk, nr;
    logic [2:0]  nk_m1;
    logic [5:0]  last_word;
    logic        words_left, out_free, gen_en, start_legal, out_hs;
    logic [9:0]  req_bits;
    logic [31:0] key_word, w_prev, w_nk, w_new;

    // Key-length decode and the per-word datapath.
    always_comb begin
        logic [3:0] nk_minus;
        case (len_q)
            2'b01:   begin nk = 4'd6; nr = 4'd12; end
            2'b10:   begin nk = 4'd8; nr = 4'd14; end
            default: begin nk = 4'd4; nr = 4'd10; end
        endcase
        nk_minus   = nk - 4'd1;
        nk_m1      = nk_minus[2:0];
        last_word  = {nr, 2'b11};
        words_left = (wcnt_q <= last_word);
        out_hs     = rk_valid_q && bus.rk_ready;
        out_free   = !rk_valid_q || bus.rk_ready;
        gen_en     = (state_q == EXPAND) && words_left && ((wcnt_q[1:0] != 2'd3) || out_free);

        req_bits    = 10'd128 + {2'b00, bus.key_len, 6'b000000};
        start_legal = (bus.key_len != 2'b11) && (req_bits <= MAX_BITS_W);

        key_word = '0;
        w_nk     = '0;
        for (int k = 0; k < NW; k++) begin
            if (wcnt_q == 6'(k)) key_word = key_q[MAX_KEY_BITS-1-32*k -: 32];
            if (nk_m1 == 3'(k))  w_nk = win_q[k];
        end
        w_prev = win_q[0];

        if (wcnt_q < {2'b00, nk})
            w_new = key_word;
        else if (mod_q == 3'd0)
            w_new = w_nk ^ sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon_q, 24'h000000};
        else if ((nk == 4'd8) && (mod_q == 3'd4))
            w_new = w_nk ^ sub_word(w_prev);
        else
            w_new = w_nk ^ w_prev;
    end

    // Next-state logic: FSM, word generation, round-key assembly and output register.
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        len_d      = len_q;
        win_d      = win_q;
        asm_d      = asm_q;
        wcnt_d     = wcnt_q;
        mod_d      = mod_q;
        rcon_d     = rcon_q;
        rk_valid_d = rk_valid_q;
        rk_data_d  = rk_data_q;
        rk_idx_d   = rk_idx_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (start_legal) begin
                        state_d = EXPAND;
                        key_d   = bus.key;
                        len_d   = bus.key_len;
                        wcnt_d  = '0;
                        mod_d   = '0;
                        rcon_d  = 8'h01;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            EXPAND: begin
                if (out_hs) rk_valid_d = 1'b0;
                if (gen_en) begin
                    win_d[0] = w_new;
                    for (int k = 1; k < NW; k++) win_d[k] = win_q[k-1];
                    wcnt_d = wcnt_q + 6'd1;
                    mod_d  = (mod_q == nk_m1) ? 3'd0 : mod_q + 3'd1;
                    // Rcon advances only after it has been consumed by a mod-0 word.
                    if ((wcnt_q >= {2'b00, nk}) && (mod_q == 3'd0))
                        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                    case (wcnt_q[1:0])
                        2'd0:    asm_d[0] = w_new;
                        2'd1:    asm_d[1] = w_new;
                        2'd2:    asm_d[2] = w_new;
                        default: begin
                            rk_data_d  = {asm_q[0], asm_q[1], asm_q[2], w_new};
                            rk_idx_d   = wcnt_q[5:2];
                            rk_valid_d = 1'b1;
                        end
                    endcase
                end
                if (out_hs && !words_left && (rk_idx_q == nr)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
`ifdef KEYEXP_ZEROIZE_EN
                    key_d     = '0;
                    win_d     = '{default: '0};
                    asm_d     = '{default: '0};
                    rk_data_d = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            key_q      <= '0;
            len_q      <= '0;
            win_q      <= '{default: '0};
            asm_q      <= '{default: '0};
            wcnt_q     <= '0;
            mod_q      <= '0;
            rcon_q     <= 8'h01;
            rk_valid_q <= 1'b0;
            rk_data_q  <= '0;
            rk_idx_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            len_q      <= len_d;
            win_q      <= win_d;
            asm_q      <= asm_d;
            wcnt_q     <= wcnt_d;
            mod_q      <= mod_d;
            rcon_q     <= rcon_d;
            rk_valid_q <= rk_valid_d;
            rk_data_q  <= rk_data_d;
            rk_idx_q   <= rk_idx_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.rk_valid = rk_valid_q;
    assign bus.rk_idx   = rk_idx_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign dbg_state    = (state_q == EXPAND);
`ifdef KEYEXP_ZEROIZE_EN
    assign bus.rk_data  = rk_valid_q ? rk_data_q : '0;
`else
    assign bus.rk_data  = rk_data_q;
`endif
endmodule

// File: tb/tb_key_expansion_seq.sv
// Directed testbench for key_expansion_seq (FIPS-197 key expansion vectors).
module tb_key_expansion_seq;
    localparam int MKB = 256;

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R256_0  = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] R256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic [127:0] exp128 [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dbg_state;

    key_expansion_seq_if #(.MAX_KEY_BITS(MKB)) bus_if ();

    key_expansion_seq #(.MAX_KEY_BITS(MKB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if.slave),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    logic [127:0] got_data [32];
    logic [3:0]   got_idx  [32];
    int n_got, done_cyc, first_valid_cyc, stall_err;
    logic [127:0] exp_q [$];

    // Driver: one-cycle start pulse from a negedge; returns at the negedge after E0.
    task automatic start_exp(input logic [255:0] k, input logic [1:0] len);
        bus_if.start   = 1'b1;
        bus_if.key     = k;
        bus_if.key_len = len;
        @(negedge clk);
        bus_if.start   = 1'b0;
    endtask

    // Collector: records accepted round keys until done (bounded), noting
    // the first valid cycle, the done cycle and any change while stalled.
    task automatic collect(input bit rand_ready);
        logic pend;
        logic [127:0] pd;
        logic [3:0] pi;
        n_got = 0; done_cyc = -1; first_valid_cyc = -1; stall_err = 0;
        pend = 1'b0; pd = '0; pi = '0;
        for (int c = 0; c <= 600; c++) begin
            if (bus_if.done) begin
                done_cyc = c;
                break;
            end
            if (pend && (!bus_if.rk_valid || bus_if.rk_data !== pd || bus_if.rk_idx !== pi))
                stall_err++;
            bus_if.rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus_if.rk_valid && first_valid_cyc < 0) first_valid_cyc = c;
            if (bus_if.rk_valid && bus_if.rk_ready) begin
                if (n_got < 32) begin
                    got_data[n_got] = bus_if.rk_data;
                    got_idx[n_got]  = bus_if.rk_idx;
                end
                n_got++;
            end
            pend = bus_if.rk_valid && !bus_if.rk_ready;
            pd   = bus_if.rk_data;
            pi   = bus_if.rk_idx;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus_if.start = 1'b0; bus_if.key = '0; bus_if.key_len = 2'b00; bus_if.rk_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus_if.rk_valid, bus_if.busy, bus_if.done, bus_if.err, bus_if.rk_idx, dbg_state} !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0", {bus_if.rk_valid, bus_if.busy, bus_if.done, bus_if.err, bus_if.rk_idx, dbg_state});
        end
        checks++;
        if (bus_if.rk_data !== 128'd0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", bus_if.rk_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aes128();
        start_exp(KEY128, 2'b00);
        checks++;
        if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL a128_busy: got %b expected 1", bus_if.busy); end
        collect(1'b0);
        checks++;
        if (n_got !== 11) begin errors++; $display("FAIL a128_count: got %0d expected 11", n_got); end
        for (int i = 0; i < 11 && i < n_got; i++) begin
            checks++;
            if (got_data[i] !== exp128[i] || got_idx[i] !== 4'(i)) begin
                errors++;
                $display("FAIL a128_rk%0d: got %h idx %0d expected %h idx %0d", i, got_data[i], got_idx[i], exp128[i], i);
            end
        end
        checks++;
        if (first_valid_cyc !== 4) begin errors++; $display("FAIL a128_first_valid: got %0d expected 4", first_valid_cyc); end
        checks++;
        if (done_cyc !== 45) begin errors++; $display("FAIL a128_done_cycle: got %0d expected 45", done_cyc); end
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.rk_valid !== 1'b0) begin
            errors++; $display("FAIL a128_idle_at_done: got busy %b valid %b expected 0 0", bus_if.busy, bus_if.rk_valid);
        end
        checks++;
`ifdef KEYEXP_ZEROIZE_EN
        if (bus_if.rk_data !== 128'd0) begin errors++; $display("FAIL a128_post_data: got %h expected 0", bus_if.rk_data); end
`else
        if (bus_if.rk_data !== exp128[10]) begin errors++; $display("FAIL a128_post_data: got %h expected %h", bus_if.rk_data, exp128[10]); end
`endif
    endtask

    // Started in the done cycle of the previous expansion.
    task automatic test_back_to_back_aes192();
        start_exp(KEY192, 2'b01);
        checks++;
        if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", bus_if.busy); end
        collect(1'b0);
        checks++;
        if (n_got !== 13) begin errors++; $display("FAIL a192_count: got %0d expected 13", n_got); end
        checks++;
        if (got_data[0] !== R192_0) begin errors++; $display("FAIL a192_rk0: got %h expected %h", got_data[0], R192_0); end
        checks++;
        if (got_data[12] !== R192_12 || got_idx[12] !== 4'd12) begin
            errors++; $display("FAIL a192_rk12: got %h idx %0d expected %h idx 12", got_data[12], got_idx[12], R192_12);
        end
        checks++;
        if (done_cyc !== 53) begin errors++; $display("FAIL a192_done_cycle: got %0d expected 53", done_cyc); end
    endtask

    task automatic test_aes256();
        start_exp(KEY256, 2'b10);
        collect(1'b0);
        checks++;
        if (n_got !== 15) begin errors++; $display("FAIL a256_count: got %0d expected 15", n_got); end
        checks++;
        if (got_data[0] !== R256_0 || got_data[1] !== R256_1) begin
            errors++; $display("FAIL a256_rk01: got %h %h expected %h %h", got_data[0], got_data[1], R256_0, R256_1);
        end
        checks++;
        if (got_data[14] !== R256_14 || got_idx[14] !== 4'd14) begin
            errors++; $display("FAIL a256_rk14: got %h idx %0d expected %h idx 14", got_data[14], got_idx[14], R256_14);
        end
        checks++;
        if (done_cyc !== 61) begin errors++; $display("FAIL a256_done_cycle: got %0d expected 61", done_cyc); end
    endtask

    task automatic test_backpressure();
        logic [127:0] e;
        for (int i = 0; i < 11; i++) exp_q.push_back(exp128[i]);
        start_exp(KEY128, 2'b00);
        collect(1'b1);
        checks++;
        if (n_got !== 11) begin errors++; $display("FAIL bp_count: got %0d expected 11", n_got); end
        for (int i = 0; i < n_got && i < 32; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
            checks++;
            if (got_data[i] !== e || got_idx[i] !== 4'(i)) begin
                errors++; $display("FAIL bp_rk%0d: got %h idx %0d expected %h idx %0d", i, got_data[i], got_idx[i], e, i);
            end
        end
        exp_q.delete();
        checks++;
        if (stall_err !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes while stalled expected 0", stall_err); end
        checks++;
        if (done_cyc < 45) begin errors++; $display("FAIL bp_done: got cycle %0d expected >= 45", done_cyc); end
    endtask

    task automatic test_error();
        bus_if.start = 1'b1; bus_if.key = KEY128; bus_if.key_len = 2'b11;
        @(negedge clk);
        bus_if.start = 1'b0;
        checks++;
        if (bus_if.err !== 1'b1 || bus_if.busy !== 1'b0) begin
            errors++; $display("FAIL err_pulse: got err %b busy %b expected 1 0", bus_if.err, bus_if.busy);
        end
        @(negedge clk);
        checks++;
        if (bus_if.err !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.rk_valid !== 1'b0) begin
            errors++; $display("FAIL err_one_cycle: got err %b busy %b valid %b expected 0 0 0", bus_if.err, bus_if.busy, bus_if.rk_valid);
        end
    endtask

    task automatic test_busy_ignore();
        bus_if.rk_ready = 1'b0;
        start_exp(KEY256, 2'b10);
        repeat (2) @(negedge clk);
        bus_if.start = 1'b1; bus_if.key = KEY128; bus_if.key_len = 2'b00;
        @(negedge clk);
        bus_if.key_len = 2'b11;
        checks++;
        if (bus_if.err !== 1'b0 || bus_if.busy !== 1'b1) begin
            errors++; $display("FAIL busy_start_legal: got err %b busy %b expected 0 1", bus_if.err, bus_if.busy);
        end
        @(negedge clk);
        bus_if.start = 1'b0;
        checks++;
        if (bus_if.err !== 1'b0) begin errors++; $display("FAIL busy_start_bad: got err %b expected 0", bus_if.err); end
        collect(1'b0);
        checks++;
        if (n_got !== 15 || got_data[14] !== R256_14) begin
            errors++; $display("FAIL busy_result: got %0d keys last %h expected 15 keys last %h", n_got, got_data[14], R256_14);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        int seen_valid;
        found = 1'b0;
        seen_valid = 0;
        bus_if.rk_ready = 1'b1;
        start_exp(KEY128, 2'b00);
        for (int c = 0; c < 100; c++) begin
            if (bus_if.rk_valid && bus_if.rk_idx == 4'd5) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rst_reach_idx5: got no rk_idx 5 expected one"); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_if.rk_valid, bus_if.busy, bus_if.done, bus_if.err, bus_if.rk_idx, dbg_state} !== 9'd0 || bus_if.rk_data !== 128'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got ctrl %b data %h expected 0 0",
                     {bus_if.rk_valid, bus_if.busy, bus_if.done, bus_if.err, bus_if.rk_idx, dbg_state}, bus_if.rk_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus_if.rk_valid || bus_if.busy) seen_valid++;
        end
        checks++;
        if (seen_valid !== 0) begin errors++; $display("FAIL rst_no_emit: got %0d active cycles expected 0", seen_valid); end
        start_exp(KEY128, 2'b00);
        collect(1'b0);
        checks++;
        if (n_got !== 11) begin errors++; $display("FAIL rst_restart_count: got %0d expected 11", n_got); end
        checks++;
        if (got_data[0] !== exp128[0] || got_idx[0] !== 4'd0 || got_data[5] !== exp128[5] || got_data[10] !== exp128[10]) begin
            errors++;
            $display("FAIL rst_restart_keys: got %h %h %h expected %h %h %h",
                     got_data[0], got_data[5], got_data[10], exp128[0], exp128[5], exp128[10]);
        end
        checks++;
        if (done_cyc !== 45) begin errors++; $display("FAIL rst_restart_done: got %0d expected 45", done_cyc); end
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_back_to_back_aes192();
        test_aes256();
        test_backpressure();
        repeat (2) @(negedge clk);
        test_error();
        test_busy_ignore();
        repeat (2) @(negedge clk);
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
